// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline stages of the ARMLEG datapath.
//   state_t             : occupancy state of a pipe_stage_skid instance
//   *_WIDTH_DEF         : default bundle / counter widths
//   <STAGE>_CTRL/DATA_W : per-stage bundle widths for the four stage instances
//   state_occupancy()   : number of entries held in a given state
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,  // nothing held, outputs show a bubble
        ST_FULL  = 2'd1,  // one entry in the main register
        ST_SKID  = 2'd2   // main and skid registers both hold entries
    } state_t;

    localparam int unsigned CTRL_WIDTH_DEF = 9;
    localparam int unsigned DATA_WIDTH_DEF = 272;
    localparam int unsigned CNT_WIDTH_DEF  = 32;

    // Per-stage bundle widths used when instantiating the four stages.
    localparam int unsigned IFID_CTRL_W  = 1;
    localparam int unsigned IFID_DATA_W  = 96;
    localparam int unsigned IDEX_CTRL_W  = 9;
    localparam int unsigned IDEX_DATA_W  = 272;
    localparam int unsigned EXMEM_CTRL_W = 5;
    localparam int unsigned EXMEM_DATA_W = 203;
    localparam int unsigned MEMWB_CTRL_W = 2;
    localparam int unsigned MEMWB_DATA_W = 133;

    function automatic logic [1:0] state_occupancy(input state_t s);
        case (s)
            ST_FULL: return 2'd1;
            ST_SKID: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter for performance statistics.
//   i_clk   : clock, counts on rising edge
//   i_rst   : asynchronous active-high reset, clears the count
//   i_inc   : add one this cycle (ignored once the count is all ones)
//   i_clr   : synchronous clear, wins over i_inc
//   o_count : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Elastic pipeline-stage register with a two-entry skid buffer, synchronous
// flush, bubble zeroing of the control bundle and a saturating stall counter.
//
// Handshake: an entry moves across an interface on a rising CLOCK edge where
// both valid and ready are 1 (in_valid & in_ready = accept,
// out_valid & out_ready = drain). A producer holding valid=1 keeps its payload
// stable until it is accepted; in_ready and out_valid come straight from flops.
//
// Ports:
//   CLOCK, RESET          : clock; asynchronous active-high reset
//   flush                 : synchronous discard of all held entries
//   in_valid/in_ready     : upstream handshake
//   in_ctrl/in_data       : upstream control / data bundles
//   out_valid/out_ready   : downstream handshake
//   out_ctrl/out_data     : head entry (out_ctrl is zero on a bubble)
//   clr_stats             : synchronous clear of stall_count
//   stall_count           : saturating count of cycles with out_valid & !out_ready
//   occupancy             : entries held (0, 1 or 2); also exposes the FSM state
// -----------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_WIDTH = 9,
    parameter int DATA_WIDTH = 272,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  clr_stats,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [1:0]            occupancy
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [CTRL_WIDTH-1:0] r_main_ctrl;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic [CTRL_WIDTH-1:0] r_skid_ctrl;
    logic [DATA_WIDTH-1:0] r_skid_data;

    logic w_accept;
    logic w_drain;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid_in;

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = r_out_valid & out_ready;

    // Next-state and register-load selection.
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next   = ST_FULL;
                    w_load_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_accept && w_drain) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_state_next   = ST_SKID;
                    w_load_skid_in = 1'b1;
                end else if (w_drain) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (w_drain) begin
                    w_state_next     = ST_FULL;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
        // Flush drops everything, including a same-cycle input; the data
        // registers keep their contents and are simply marked invalid.
        if (flush) begin
            w_state_next     = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid_in   = 1'b0;
        end
    end

    // State plus the two registered handshake outputs, derived from the next
    // state so that neither depends combinationally on the current inputs.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next != ST_SKID);
            r_out_valid <= (w_state_next != ST_EMPTY);
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid_in) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .i_clk   (CLOCK),
        .i_rst   (RESET),
        .i_inc   (r_out_valid & ~out_ready),
        .i_clr   (clr_stats),
        .o_count (stall_count)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    // Bubble zeroing keeps downstream write-enable style bits inert.
    assign out_ctrl  = r_main_ctrl & {CTRL_WIDTH{r_out_valid}};
    assign out_data  = r_main_data;
    assign occupancy = state_occupancy(r_state);

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, elastic pipeline-stage register for the ARMLEG datapath: the generalised successor of the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latch blocks. Carries a control bundle and a data bundle of configurable width, adds valid/ready flow control with a two-entry skid buffer, and supports a synchronous flush. When the stage holds a bubble, its control outputs are forced to zero, so downstream regWrite/memWrite-type bits are inert. It also provides a saturating back-pressure (stall) counter for performance monitoring.

## Interface
Parameters:
- CTRL_WIDTH, default 9: width of the control bundle (e.g. ALUop, ALUsrc, isBranch, memRead, memWrite, regWrite, memToReg); zeroed on bubble.
- DATA_WIDTH, default 272: width of the data bundle (PC, regData1/2, signExtend, ALUcontrol, writeReg); never zeroed except by reset.
- CNT_WIDTH, default 32: stall counter width.

Ports:
- CLOCK  in  1  sole clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all held entries.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept; driven directly from a register.
- in_ctrl  in  CTRL_WIDTH  upstream control bundle.
- in_data  in  DATA_WIDTH  upstream data bundle.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts the output entry.
- out_ctrl  out  CTRL_WIDTH  control bundle; all zero whenever out_valid=0.
- out_data  out  DATA_WIDTH  data bundle of the head entry.
- clr_stats  in  1  synchronous clear of stall_count.
- stall_count  out  CNT_WIDTH  saturating count of back-pressured cycles.
- occupancy  out  2  entries held (0, 1 or 2).

## Operation
- Storage: main register (drives the outputs) plus skid register. Accept = in_valid & in_ready; drain = out_valid & out_ready.
- States and transitions:
  - EMPTY (occupancy 0, in_ready=1): accept → FULL, main ← input.
  - FULL (occupancy 1, in_ready=1):
    - accept & drain → FULL, main ← input.
    - accept & !drain → SKID, skid ← input.
    - !accept & drain → EMPTY.
    - !accept & !drain → stay.
  - SKID (occupancy 2, in_ready=0): drain → FULL, main ← skid; else stay.
- flush=1: next state EMPTY regardless of in_valid/out_ready; any same-cycle input is dropped. Entries already drained that cycle count as delivered. Data registers are not cleared.
- out_ctrl = main_ctrl & {CTRL_WIDTH{out_valid}}. out_data shows main_data even when invalid.
- stall_count: +1 each cycle with out_valid & !out_ready; holds at all-ones. clr_stats has priority over increment. Not affected by flush.
- Order is strictly FIFO; no entry is duplicated or lost except by flush.

## Timing
- Latency: accept at edge N → out_valid=1 and data visible after edge N, with no combinational path from input to output.
- Throughput: one entry per cycle while out_ready=1.
- in_ready and out_valid are pure register outputs; in_ready has no combinational dependence on out_ready.
- in_ready falls in the cycle after entering SKID, and rises in the cycle after the first drain from SKID.
- Reset (asynchronous, immediate): state EMPTY, in_ready=1, out_valid=0, out_ctrl=0, out_data=0, skid=0, stall_count=0, occupancy=0. Reset mid-transfer discards all held entries.
- Simultaneous flush + clr_stats: both take effect.

## Structure
- Shared package pipe_pkg: state enum (ST_EMPTY, ST_FULL, ST_SKID) and the default bundle-width constants used by all four stage instances.
- Sub-module sat_counter (parameter WIDTH; inputs inc, clr): reused for stall_count and other performance counters.
- The stage instances replace the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches, with per-stage CTRL_WIDTH/DATA_WIDTH values.

## Test plan
- Streaming: out_ready=1, in_valid=1 for 8 cycles with data 0..7 → out_data sequence 0..7 one cycle late, occupancy=1, stall_count=0.
- Back-pressure: fill with A, B while out_ready=0 → occupancy=2, in_ready=0 the next cycle. Then out_ready=1 → A, then B, in order; stall_count equals the number of held cycles.
- Bubble zeroing: in_ctrl=9'h1FF accepted then drained with no new input → out_valid=0 and out_ctrl=0, while out_data keeps its last value.
- Flush with in SKID plus a concurrent in_valid → next cycle occupancy=0, out_valid=0, in_ready=1; the concurrent input never appears.
- Saturation: CNT_WIDTH=4, out_ready=0 for 20 cycles → stall_count=15; clr_stats → 0.
- Async reset asserted between clock edges while FULL → outputs reach reset values immediately, without waiting for CLOCK.
